mul_div_unit: RTL and testbench

//   Multi-cycle HI/LO multiply/divide unit in the EX stage, directly upstream of EX_MEM.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/mul_div_unit_if.sv | 18 +
 rtl/mul_div_unit.sv | 114 +++++++++++
 tb/tb_mul_div_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the EX-stage HI/LO multiply/divide unit.
//   md_op_t      : 3-bit MD operation code carried with the E-stage instruction
//   MD_*         : operation encodings
//   MD_*_DFLT    : default busy-cycle counts for multiply and divide
//   is_md_arith  : true for the four ops that occupy the unit for several cycles
package mips_pkg;

    typedef logic [2:0] md_op_t;

    localparam md_op_t MD_NONE  = 3'd0;
    localparam md_op_t MD_MULT  = 3'd1;
    localparam md_op_t MD_MULTU = 3'd2;
    localparam md_op_t MD_DIV   = 3'd3;
    localparam md_op_t MD_DIVU  = 3'd4;
    localparam md_op_t MD_MTHI  = 3'd5;
    localparam md_op_t MD_MTLO  = 3'd6;

    localparam int MD_MULT_CYCLES_DFLT = 5;
    localparam int MD_DIV_CYCLES_DFLT  = 10;

    function automatic logic is_md_arith(input md_op_t op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Bundle between the E stage / hazard unit and the multiply/divide unit.
//   master : pipeline side, drives Req_M, md_op_E, mf_hi_E, A_E, B_E
//   slave  : the unit, drives md_out_E, busy_E, md_stall
interface mul_div_unit_if;
    logic                 Req_M;
    mips_pkg::md_op_t     md_op_E;
    logic                 mf_hi_E;
    logic [31:0]          A_E;
    logic [31:0]          B_E;
    logic [31:0]          md_out_E;
    logic                 busy_E;
    logic                 md_stall;

    modport master (output Req_M, md_op_E, mf_hi_E, A_E, B_E,
                    input  md_out_E, busy_E, md_stall);
    modport slave  (input  Req_M, md_op_E, mf_hi_E, A_E, B_E,
                    output md_out_E, busy_E, md_stall);
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit (E stage).
// The result is computed combinationally in the start cycle and parked in shadow
// registers; a down-counter models the unit latency and HI/LO are committed on the
// edge where the counter leaves 1. mthi/mtlo write HI/LO directly when idle.
// Ports:
//   clk, reset : pipeline clock, asynchronous active-high reset
//   md (slave) : operation request, operands, M-stage kill, HI/LO read-back,
//                busy and stall outputs
module mul_div_unit
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DFLT,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DFLT
) (
    input  logic           clk,
    input  logic           reset,
    mul_div_unit_if.slave  md
);

    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] shadow_hi_q, shadow_hi_d, shadow_lo_q, shadow_lo_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;        // 0 for divide-by-zero: run the latency, skip commit

    logic        busy, start;
    logic [63:0] prod_s, prod_u;
    logic        div_ovf;
    logic [31:0] safe_b, quo_s, rem_s, quo_u, rem_u;

    assign busy  = (cnt_q != 4'd0);
    assign start = is_md_arith(md.md_op_E) && !md.Req_M && !busy;

    // Datapath, only meaningful in the start cycle.
    assign prod_s = {{32{md.A_E[31]}}, md.A_E} * {{32{md.B_E[31]}}, md.B_E};
    assign prod_u = {32'b0, md.A_E} * {32'b0, md.B_E};

    // Divisor forced to 1 for B==0 and for the single signed-overflow case so the
    // divider never sees an undefined operation; those cases are muxed out below.
    assign div_ovf = (md.A_E == 32'h8000_0000) && (md.B_E == 32'hFFFF_FFFF);
    assign safe_b  = (md.B_E == 32'd0 || div_ovf) ? 32'd1 : md.B_E;
    assign quo_s   = div_ovf ? 32'h8000_0000 : 32'($signed(md.A_E) / $signed(safe_b));
    assign rem_s   = div_ovf ? 32'd0         : 32'($signed(md.A_E) % $signed(safe_b));
    assign quo_u   = md.A_E / safe_b;
    assign rem_u   = md.A_E % safe_b;

    always_comb begin
        hi_d        = hi_q;
        lo_d        = lo_q;
        shadow_hi_d = shadow_hi_q;
        shadow_lo_d = shadow_lo_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        if (busy) begin
            // In-flight op belongs to an older instruction: Req_M does not abort it,
            // and any new md_op_E is ignored until it completes.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1 && wr_q) begin
                hi_d = shadow_hi_q;
                lo_d = shadow_lo_q;
            end
        end else if (!md.Req_M) begin
            unique case (md.md_op_E)
                MD_MULT: begin
                    {shadow_hi_d, shadow_lo_d} = prod_s;
                    cnt_d = 4'(MULT_CYCLES);
                    wr_d  = 1'b1;
                end
                MD_MULTU: begin
                    {shadow_hi_d, shadow_lo_d} = prod_u;
                    cnt_d = 4'(MULT_CYCLES);
                    wr_d  = 1'b1;
                end
                MD_DIV: begin
                    shadow_hi_d = rem_s;
                    shadow_lo_d = quo_s;
                    cnt_d = 4'(DIV_CYCLES);
                    wr_d  = (md.B_E != 32'd0);
                end
                MD_DIVU: begin
                    shadow_hi_d = rem_u;
                    shadow_lo_d = quo_u;
                    cnt_d = 4'(DIV_CYCLES);
                    wr_d  = (md.B_E != 32'd0);
                end
                MD_MTHI: hi_d = md.A_E;
                MD_MTLO: lo_d = md.A_E;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            shadow_hi_q <= 32'd0;
            shadow_lo_q <= 32'd0;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
        end else begin
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            shadow_hi_q <= shadow_hi_d;
            shadow_lo_q <= shadow_lo_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
        end
    end

    assign md.busy_E   = busy;
    assign md.md_stall = busy | start;
    assign md.md_out_E = md.mf_hi_E ? hi_q : lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed scenarios plus random arithmetic,
// checked against an arithmetic reference of HI/LO kept in 64-bit integers.
module tb_mul_div_unit;
    import mips_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    int   total  = 0;
    int   passed = 0;
    logic [31:0] exp_hi = 32'd0, exp_lo = 32'd0;

    always #5 clk = ~clk;

    mul_div_unit_if mif ();

    mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mif.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_hilo(input string tag);
        mif.mf_hi_E = 1'b1;
        #1 check({tag, "_hi"}, mif.md_out_E, exp_hi);
        mif.mf_hi_E = 1'b0;
        #1 check({tag, "_lo"}, mif.md_out_E, exp_lo);
    endtask

    // Reference: what HI/LO become when an arithmetic op completes.
    task automatic model(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] h, output logic [31:0] l);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        h = exp_hi;
        l = exp_lo;
        case (op)
            MD_MULT:  begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
            MD_MULTU: begin p = 64'(ua * ub); h = p[63:32]; l = p[31:0]; end
            MD_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; h = 32'(r); l = 32'(q); end
            MD_DIVU:  if (b != 0) begin h = 32'(ua % ub); l = 32'(ua / ub); end
            default: ;
        endcase
    endtask

    task automatic drive(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic req);
        mif.md_op_E = op;
        mif.A_E     = a;
        mif.B_E     = b;
        mif.Req_M   = req;
    endtask

    // Issue an arithmetic op from idle and follow it to commit. With inject set,
    // mtlo/divu/mthi+Req_M are driven while busy and must be ignored.
    task automatic run_arith(input string tag, input md_op_t op, input logic [31:0] a,
                             input logic [31:0] b, input bit inject);
        logic [31:0] nh, nl;
        int n;
        n = (op == MD_MULT || op == MD_MULTU) ? MC : DC;
        model(op, a, b, nh, nl);
        @(negedge clk);
        drive(op, a, b, 1'b0);
        #1 check({tag, "_stall_start"}, 32'(mif.md_stall), 32'd1);
        @(posedge clk);
        @(negedge clk);
        drive(MD_NONE, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            check({tag, "_busy"}, 32'(mif.busy_E), 32'd1);
            if (i == 0 || i == n - 1) check_hilo({tag, "_old"});
            if (inject) begin
                case (i)
                    1: drive(MD_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b0);
                    2: drive(MD_DIVU, 32'd100, 32'd7, 1'b0);
                    3: drive(MD_MTHI, 32'hCAFE_F00D, 32'd0, 1'b1);
                    default: drive(MD_NONE, 32'd0, 32'd0, 1'b0);
                endcase
                if (i >= 1 && i <= 3) #1 check({tag, "_stall_busy"}, 32'(mif.md_stall), 32'd1);
            end
        end
        @(negedge clk);
        exp_hi = nh;
        exp_lo = nl;
        check({tag, "_busy_done"}, 32'(mif.busy_E), 32'd0);
        check({tag, "_stall_done"}, 32'(mif.md_stall), 32'd0);
        check_hilo({tag, "_new"});
    endtask

    task automatic run_mt(input string tag, input md_op_t op, input logic [31:0] a,
                          input logic req);
        @(negedge clk);
        drive(op, a, 32'd0, req);
        #1 check({tag, "_stall"}, 32'(mif.md_stall), 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive(MD_NONE, 32'd0, 32'd0, 1'b0);
        if (!req) begin
            if (op == MD_MTHI) exp_hi = a;
            else exp_lo = a;
        end
        check({tag, "_busy"}, 32'(mif.busy_E), 32'd0);
        check_hilo(tag);
    endtask

    initial begin
        md_op_t op;
        logic [31:0] a, b;
        reset = 1'b1;
        mif.mf_hi_E = 1'b0;
        drive(MD_NONE, 32'd0, 32'd0, 1'b0);
        #12;
        check("rst_busy", 32'(mif.busy_E), 32'd0);
        check("rst_stall", 32'(mif.md_stall), 32'd0);
        check_hilo("rst");
        reset = 1'b0;

        // Directed arithmetic
        run_arith("mult_neg2x3", MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult_lo_const", exp_lo, 32'hFFFF_FFFA);
        run_arith("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_lo_const", exp_lo, 32'hFFFF_FFFD);
        run_arith("divu_m7_2", MD_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("divu_lo_const", exp_lo, 32'h7FFF_FFFC);
        run_arith("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // mthi/mtlo with and without kill
        run_mt("mthi_killed", MD_MTHI, 32'h1234_5678, 1'b1);
        run_mt("mthi", MD_MTHI, 32'h1234_5678, 1'b0);

        // Divide by zero keeps HI/LO
        run_mt("mthi5", MD_MTHI, 32'd5, 1'b0);
        run_mt("mtlo6", MD_MTLO, 32'd6, 1'b0);
        run_arith("div_by0", MD_DIV, 32'd77, 32'd0, 1'b0);
        run_arith("divu_by0", MD_DIVU, 32'd77, 32'd0, 1'b0);

        // Killed MULT never starts
        @(negedge clk);
        drive(MD_MULT, 32'd9, 32'd9, 1'b1);
        #1 check("mult_killed_stall", 32'(mif.md_stall), 32'd0);
        @(negedge clk);
        drive(MD_NONE, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("mult_killed_busy", 32'(mif.busy_E), 32'd0);
            @(negedge clk);
        end
        check_hilo("mult_killed");

        // Ops and Req_M during busy are ignored; the MULT still commits
        run_arith("mult_inject", MD_MULT, 32'h0001_0003, 32'hFFFF_0007, 1'b1);

        // Asynchronous reset mid-division
        @(negedge clk);
        drive(MD_DIV, 32'd1000, 32'd3, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(MD_NONE, 32'd0, 32'd0, 1'b0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        #1 check("arst_busy", 32'(mif.busy_E), 32'd0);
        check_hilo("arst");
        @(negedge clk);
        reset = 1'b0;
        repeat (DC + 2) @(negedge clk);
        check("arst_after_busy", 32'(mif.busy_E), 32'd0);
        check_hilo("arst_after");

        // Random arithmetic
        for (int k = 0; k < 16; k++) begin
            op = md_op_t'($urandom_range(1, 4));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
            run_arith($sformatf("rnd%0d_op%0d", k, op), op, a, b, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
